reg_dump_streamer: RTL and testbench
====================================

# reg_dump_streamer

Read-side companion to `reg_file`. On a start pulse it walks every register of the 16 x 32 register file through both combinational read ports, two registers per fetch, and streams them out in ascending address order over a valid/ready interface. It sits beside the datapath, shares `reg_file`'s read ports while `busy`, and feeds debug/trace or state-dump logic.

## Interface
- `DATA_WIDTH`, default 32: register width; matches `reg_file` data.
- `ADDR_WIDTH`, default 4: register address width; the dump covers 2^ADDR_WIDTH words; minimum 1.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `reset_n`  in  1: asynchronous, active-low reset.
- `start`  in  1: request a full dump; sampled only in IDLE.
- `busy`  out  1: high while a dump is in progress; the read ports belong to this block.
- `done`  out  1: one-cycle pulse the cycle after the last word's handshake.
- `read_addr1`  out  ADDR_WIDTH: to `reg_file` read_addr1; even address of the pair being fetched.
- `read_addr2`  out  ADDR_WIDTH: to `reg_file` read_addr2; `read_addr1` + 1.
- `read_data1`  in  DATA_WIDTH: from `reg_file`; combinational read of `read_addr1`.
- `read_data2`  in  DATA_WIDTH: from `reg_file`; combinational read of `read_addr2`.
- `out_valid`  out  1: `out_data`/`out_addr`/`out_last` hold a word.
- `out_ready`  in  1: consumer accepts; handshake = `out_valid` & `out_ready` at a rising edge.
- `out_data`  out  DATA_WIDTH: register contents.
- `out_addr`  out  ADDR_WIDTH: register index of `out_data`.
- `out_last`  out  1: high with the word at address 2^ADDR_WIDTH-1.

## Operation
- States: IDLE, STREAM.
- Internal state: `base` (next even address to fetch), a 2-entry buffer (slot0 = even word, slot1 = odd word), `head` (0/1), `count` (0..2), `fetched_all` flag.
- `read_addr1` = `base`; `read_addr2` = `base` | 1. Both are driven in every state.
- IDLE: `base` = 0, `count` = 0. If `start` = 1, capture `read_data1`/`read_data2` into slot0/slot1, set `count` = 2, `head` = 0, `base` += 2, and go to STREAM. If `base` wraps to 0, set `fetched_all`.
- STREAM: outputs present slot[`head`] with `out_addr` = its index, and `out_valid` = (`count` != 0).
  - A handshake advances `head` and decrements `count`.
  - Refill: when `count` = 1, a handshake occurs, and `fetched_all` = 0, capture the next pair in the same edge (`count` = 2, `head` = 0, `base` += 2). This sustains one word per cycle under continuous `out_ready`.
  - Handshake on the word with `out_last` = 1 → go to IDLE and pulse `done` for the next cycle.
- `out_valid` never deasserts without a handshake; outputs stay stable while `out_valid` & !`out_ready`.
- `start` is ignored in STREAM. `start` held high through `done` begins a new dump in the `done` cycle, since the state is then IDLE.
- Coherence: words are snapshotted at capture. A `reg_file` write landing on the capture edge is not seen, because the old value is captured.
- Address arithmetic is modulo 2^ADDR_WIDTH. `base` wrapping to 0 marks the final pair.

## Timing
- Reset values: `busy` 0, `done` 0, `out_valid` 0, `out_data` 0, `out_addr` 0, `out_last` 0, `read_addr1` 0, `read_addr2` 1, state IDLE.
- Reset asserted mid-dump aborts it immediately (asynchronous). The buffer is discarded, `out_valid` drops, and no `done` pulse is issued.
- Latency: `start` sampled at edge N → `out_valid` = 1 and `busy` = 1 in cycle N+1, carrying addr 0.
- Throughput with `out_ready` tied high: word k is valid in cycle N+1+k. The last handshake is at the end of cycle N+16 (ADDR_WIDTH = 4). `done` = 1 and `busy` = 0 in cycle N+17.
- `busy` = (state == STREAM); `done` is registered and high for exactly one cycle.
- Back-pressure: any number of stall cycles is allowed, with no word loss or duplication.

## Test plan
- Preload reg[i] = 0x1000_0000 + i via `reg_file`; pulse `start` with `out_ready` = 1 → 16 consecutive words, addr 0..15, data 0x1000_0000..0x1000_000F. `out_last` is high only on addr 15; `done` pulses 1 cycle after.
- Same preload with `out_ready` toggling 1,0,0,1,… → identical sequence, outputs stable during stalls, exactly 16 handshakes.
- Write reg[2] = 0xFFFF_FFFF on the cycle after start, before pair (2,3) is captured → dump shows 0xFFFF_FFFF at addr 2. Writing reg[0] = 0xDEAD_BEEF on the start edge → dump shows the old reg[0].
- Pulse `start` repeatedly during STREAM → no restart; still exactly 16 words and one `done`.
- Assert `reset_n` = 0 after 5 words → all outputs at reset values immediately; a new `start` dumps from addr 0.
- `start` held high continuously → back-to-back dumps; the second dump's addr 0 is valid in the cycle after `done`.

Source files
------------

// File: rtl/reg_dump_streamer.sv
`default_nettype none
// ============================================================================
// Module   : reg_dump_streamer
// Purpose  : Walks a 2^ADDR_WIDTH-entry register file two words per fetch and
//            streams the contents in ascending address order over valid/ready.
// Revision : 1.0 - initial release
// ============================================================================
module reg_dump_streamer #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] read_addr1,
    output logic [ADDR_WIDTH-1:0] read_addr2,
    input  logic [DATA_WIDTH-1:0] read_data1,
    input  logic [DATA_WIDTH-1:0] read_data2,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [ADDR_WIDTH-1:0] out_addr,
    output logic                  out_last
);

    typedef enum logic [0:0] {
        S_IDLE   = 1'b0,
        S_STREAM = 1'b1
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] C_TWO = ADDR_WIDTH'(2);
    localparam logic [ADDR_WIDTH-1:0] C_ONE = ADDR_WIDTH'(1);

    state_t                r_state, w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_base, w_base_nxt, w_base_inc;
    logic [DATA_WIDTH-1:0] r_slot0, r_slot1, w_slot0_nxt, w_slot1_nxt;
    logic                  r_head, w_head_nxt;
    logic [1:0]            r_count, w_count_nxt;
    logic                  r_fetched_all, w_fetched_all_nxt;
    logic                  r_done, w_done_nxt;
    logic                  w_valid, w_hs, w_last;
    logic [ADDR_WIDTH-1:0] w_word_addr;

    assign w_base_inc  = r_base + C_TWO;
    assign w_valid     = (r_state == S_STREAM) && (r_count != 2'd0);
    // The buffered pair was fetched from the even address two below base.
    assign w_word_addr = (r_base - C_TWO) | ADDR_WIDTH'(r_head);
    assign w_last      = w_valid && (w_word_addr == '1);
    assign w_hs        = w_valid && out_ready;

    assign read_addr1 = r_base;
    assign read_addr2 = r_base | C_ONE;
    assign busy       = (r_state == S_STREAM);
    assign done       = r_done;
    assign out_valid  = w_valid;
    assign out_data   = w_valid ? (r_head ? r_slot1 : r_slot0) : '0;
    assign out_addr   = w_valid ? w_word_addr : '0;
    assign out_last   = w_last;

    always_comb begin
        w_state_nxt       = r_state;
        w_base_nxt        = r_base;
        w_slot0_nxt       = r_slot0;
        w_slot1_nxt       = r_slot1;
        w_head_nxt        = r_head;
        w_count_nxt       = r_count;
        w_fetched_all_nxt = r_fetched_all;
        w_done_nxt        = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_base_nxt        = '0;
                w_count_nxt       = 2'd0;
                w_fetched_all_nxt = 1'b0;
                if (start) begin
                    w_slot0_nxt       = read_data1;
                    w_slot1_nxt       = read_data2;
                    w_count_nxt       = 2'd2;
                    w_head_nxt        = 1'b0;
                    w_base_nxt        = w_base_inc;
                    w_fetched_all_nxt = (w_base_inc == '0);
                    w_state_nxt       = S_STREAM;
                end
            end
            S_STREAM: begin
                if (w_hs) begin
                    if (w_last) begin
                        w_state_nxt       = S_IDLE;
                        w_done_nxt        = 1'b1;
                        w_count_nxt       = 2'd0;
                        w_head_nxt        = 1'b0;
                        w_base_nxt        = '0;
                        w_fetched_all_nxt = 1'b0;
                    end else if ((r_count == 2'd1) && !r_fetched_all) begin
                        // Refill on the same edge as the odd word leaves.
                        w_slot0_nxt       = read_data1;
                        w_slot1_nxt       = read_data2;
                        w_count_nxt       = 2'd2;
                        w_head_nxt        = 1'b0;
                        w_base_nxt        = w_base_inc;
                        w_fetched_all_nxt = (w_base_inc == '0);
                    end else begin
                        w_head_nxt  = ~r_head;
                        w_count_nxt = r_count - 2'd1;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= S_IDLE;
            r_base        <= '0;
            r_slot0       <= '0;
            r_slot1       <= '0;
            r_head        <= 1'b0;
            r_count       <= 2'd0;
            r_fetched_all <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_base        <= w_base_nxt;
            r_slot0       <= w_slot0_nxt;
            r_slot1       <= w_slot1_nxt;
            r_head        <= w_head_nxt;
            r_count       <= w_count_nxt;
            r_fetched_all <= w_fetched_all_nxt;
            r_done        <= w_done_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_reg_dump_streamer.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_dump_streamer
// Purpose  : Directed self-checking bench for reg_dump_streamer with a small
//            register-file model on the read ports.
// Revision : 1.0 - initial release
// ============================================================================
module tb_reg_dump_streamer;
    localparam int DW = 32;
    localparam int AW = 4;
    localparam int NW = 16;

    logic          clk = 1'b0;
    logic          reset_n, start, out_ready, busy, done, out_valid, out_last;
    logic [AW-1:0] read_addr1, read_addr2, out_addr;
    logic [DW-1:0] read_data1, read_data2, out_data;
    logic          we;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic [DW-1:0] mem [NW];

    always #5 clk = ~clk;

    always @(posedge clk) if (we) mem[wa] <= wd;
    assign read_data1 = mem[read_addr1];
    assign read_data2 = mem[read_addr2];

    reg_dump_streamer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .busy(busy), .done(done),
        .read_addr1(read_addr1), .read_addr2(read_addr2),
        .read_data1(read_data1), .read_data2(read_data2),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_addr(out_addr), .out_last(out_last)
    );

    int checks = 0;
    int errors = 0;
    int n_hs, done_count, done_c, busy_at_done, stall_bad;
    logic [AW-1:0] got_addr [64];
    logic [DW-1:0] got_data [64];
    logic          got_last [64];
    int            got_c    [64];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0; start = 1'b0; out_ready = 1'b0; we = 1'b0;
        tick(); tick();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic preload();
        for (int i = 0; i < NW; i++) begin
            we = 1'b1; wa = AW'(i); wd = DW'(32'h1000_0000 + i);
            tick();
        end
        we = 1'b0;
    endtask

    // mode 0: ready high; mode 1: ready 1,0,0,1 repeating.
    // start_mode 0: untouched; 1: toggle for 15 cycles; >=2: drop at that cycle.
    task automatic stream(input int mode, input int ncyc, input int start_mode);
        logic          pv, pr, pl;
        logic [AW-1:0] pa;
        logic [DW-1:0] pd;
        n_hs = 0; done_count = 0; done_c = -1; busy_at_done = -1; stall_bad = 0;
        pv = 1'b0; pr = 1'b0; pl = 1'b0; pa = '0; pd = '0;
        for (int c = 1; c <= ncyc; c++) begin
            out_ready = (mode == 0) ? 1'b1 : (((c - 1) % 4 == 0) || ((c - 1) % 4 == 3));
            if (start_mode == 1) start = (c <= 15) ? (c % 2 == 1) : 1'b0;
            else if (start_mode >= 2 && c == start_mode) start = 1'b0;
            if (pv && !pr && (!out_valid || out_addr !== pa || out_data !== pd || out_last !== pl))
                stall_bad++;
            if (done) begin
                done_count++;
                if (done_c < 0) begin done_c = c; busy_at_done = int'(busy); end
            end
            if (out_valid && out_ready && n_hs < 64) begin
                got_addr[n_hs] = out_addr; got_data[n_hs] = out_data;
                got_last[n_hs] = out_last; got_c[n_hs] = c;
                n_hs++;
            end
            pv = out_valid; pr = out_ready; pa = out_addr; pd = out_data; pl = out_last;
            tick();
            we = 1'b0;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; start = 1'b0; out_ready = 1'b0; we = 1'b0; wa = '0; wd = '0;
        tick(); tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
        checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_data: got %h expected 0", out_data); end
        checks++; if (out_addr !== '0) begin errors++; $display("FAIL reset_addr: got %h expected 0", out_addr); end
        checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL reset_last: got %b expected 0", out_last); end
        checks++; if (read_addr1 !== 4'd0) begin errors++; $display("FAIL reset_ra1: got %h expected 0", read_addr1); end
        checks++; if (read_addr2 !== 4'd1) begin errors++; $display("FAIL reset_ra2: got %h expected 1", read_addr2); end
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_stream();
        preload();
        start = 1'b1; out_ready = 1'b1;
        tick();
        start = 1'b0;
        stream(0, 20, 0);
        checks++; if (n_hs !== 16) begin errors++; $display("FAIL stream_count: got %0d expected 16", n_hs); end
        for (int k = 0; k < 16; k++) begin
            checks++;
            if (got_addr[k] !== AW'(k) || got_data[k] !== DW'(32'h1000_0000 + k) ||
                got_last[k] !== (k == 15) || got_c[k] !== k + 1) begin
                errors++;
                $display("FAIL stream_word%0d: got addr %h data %h last %b cycle %0d expected addr %h data %h last %b cycle %0d",
                         k, got_addr[k], got_data[k], got_last[k], got_c[k],
                         AW'(k), DW'(32'h1000_0000 + k), (k == 15), k + 1);
            end
        end
        checks++; if (done_count !== 1) begin errors++; $display("FAIL stream_done_count: got %0d expected 1", done_count); end
        checks++; if (done_c !== 17) begin errors++; $display("FAIL stream_done_cycle: got %0d expected 17", done_c); end
        checks++; if (busy_at_done !== 0) begin errors++; $display("FAIL stream_busy_at_done: got %0d expected 0", busy_at_done); end
    endtask

    task automatic test_backpressure();
        preload();
        start = 1'b1;
        tick();
        start = 1'b0;
        stream(1, 60, 0);
        checks++; if (n_hs !== 16) begin errors++; $display("FAIL bp_count: got %0d expected 16", n_hs); end
        for (int k = 0; k < 16; k++) begin
            checks++;
            if (got_addr[k] !== AW'(k) || got_data[k] !== DW'(32'h1000_0000 + k) || got_last[k] !== (k == 15)) begin
                errors++;
                $display("FAIL bp_word%0d: got addr %h data %h last %b expected addr %h data %h last %b",
                         k, got_addr[k], got_data[k], got_last[k], AW'(k), DW'(32'h1000_0000 + k), (k == 15));
            end
        end
        checks++; if (stall_bad !== 0) begin errors++; $display("FAIL bp_stall_stable: got %0d changes expected 0", stall_bad); end
        checks++; if (done_count !== 1) begin errors++; $display("FAIL bp_done_count: got %0d expected 1", done_count); end
    endtask

    task automatic test_coherence();
        preload();
        we = 1'b1; wa = 4'd0; wd = 32'hDEAD_BEEF;
        start = 1'b1;
        tick();
        start = 1'b0;
        we = 1'b1; wa = 4'd2; wd = 32'hFFFF_FFFF;
        stream(0, 20, 0);
        checks++; if (n_hs !== 16) begin errors++; $display("FAIL coh_count: got %0d expected 16", n_hs); end
        checks++; if (got_data[0] !== 32'h1000_0000) begin errors++; $display("FAIL coh_word0: got %h expected 10000000", got_data[0]); end
        checks++; if (got_data[1] !== 32'h1000_0001) begin errors++; $display("FAIL coh_word1: got %h expected 10000001", got_data[1]); end
        checks++; if (got_data[2] !== 32'hFFFF_FFFF) begin errors++; $display("FAIL coh_word2: got %h expected ffffffff", got_data[2]); end
        checks++; if (got_data[3] !== 32'h1000_0003) begin errors++; $display("FAIL coh_word3: got %h expected 10000003", got_data[3]); end
    endtask

    task automatic test_start_ignored();
        preload();
        start = 1'b1;
        tick();
        stream(0, 25, 1);
        checks++; if (n_hs !== 16) begin errors++; $display("FAIL ign_count: got %0d expected 16", n_hs); end
        checks++; if (done_count !== 1) begin errors++; $display("FAIL ign_done_count: got %0d expected 1", done_count); end
        checks++; if (got_addr[15] !== 4'd15 || got_c[15] !== 16) begin
            errors++; $display("FAIL ign_last_word: got addr %h cycle %0d expected addr f cycle 16", got_addr[15], got_c[15]);
        end
    endtask

    task automatic test_reset_abort();
        preload();
        start = 1'b1;
        tick();
        start = 1'b0;
        stream(0, 5, 0);
        checks++; if (n_hs !== 5) begin errors++; $display("FAIL abort_pre_count: got %0d expected 5", n_hs); end
        reset_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL abort_flags: got valid %b busy %b expected 0 0", out_valid, busy);
        end
        checks++; if (out_data !== '0 || out_addr !== '0 || out_last !== 1'b0) begin
            errors++; $display("FAIL abort_outputs: got data %h addr %h last %b expected 0 0 0", out_data, out_addr, out_last);
        end
        checks++; if (read_addr1 !== 4'd0 || read_addr2 !== 4'd1) begin
            errors++; $display("FAIL abort_raddr: got %h %h expected 0 1", read_addr1, read_addr2);
        end
        tick();
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL abort_no_done: got %b expected 0", done); end
        reset_n = 1'b1;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        stream(0, 20, 0);
        checks++; if (n_hs !== 16) begin errors++; $display("FAIL abort_redump_count: got %0d expected 16", n_hs); end
        checks++; if (got_addr[0] !== 4'd0 || got_data[0] !== 32'h1000_0000) begin
            errors++; $display("FAIL abort_redump_first: got addr %h data %h expected 0 10000000", got_addr[0], got_data[0]);
        end
        checks++; if (done_count !== 1) begin errors++; $display("FAIL abort_redump_done: got %0d expected 1", done_count); end
    endtask

    task automatic test_back_to_back();
        preload();
        start = 1'b1;
        tick();
        stream(0, 36, 34);
        checks++; if (n_hs !== 32) begin errors++; $display("FAIL b2b_count: got %0d expected 32", n_hs); end
        checks++; if (done_count !== 2) begin errors++; $display("FAIL b2b_done_count: got %0d expected 2", done_count); end
        checks++; if (got_c[16] !== 18 || got_addr[16] !== 4'd0 || got_data[16] !== 32'h1000_0000) begin
            errors++; $display("FAIL b2b_second_first: got cycle %0d addr %h data %h expected cycle 18 addr 0 data 10000000",
                                got_c[16], got_addr[16], got_data[16]);
        end
        checks++; if (got_addr[31] !== 4'd15 || got_last[31] !== 1'b1) begin
            errors++; $display("FAIL b2b_second_last: got addr %h last %b expected f 1", got_addr[31], got_last[31]);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        do_reset();
        test_backpressure();
        do_reset();
        test_coherence();
        do_reset();
        test_start_ignored();
        do_reset();
        test_reset_abort();
        do_reset();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
